// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer: shares one binary neuron datapath (XNOR + popcount +
// threshold) across NUM_NEURONS logical neurons to evaluate a full BNN layer.
// It owns the per-neuron weight bank, issues one (input, weight) pair per
// neuron and assembles the 1-bit results into out_vec with a done pulse.
module bnn_layer_sequencer #(
    parameter int IN_W        = 8,
    parameter int NUM_NEURONS = 4,
    parameter int DP_LATENCY  = 2,
    localparam int AW         = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [IN_W-1:0]        cfg_wdata,
    input  logic                   start,
    input  logic [IN_W-1:0]        in_data,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] out_vec,
    output logic                   dp_valid,
    output logic [IN_W-1:0]        dp_in,
    output logic [IN_W-1:0]        dp_weight,
    input  logic                   dp_result
);

    localparam int              CW    = $clog2(DP_LATENCY + 1);
    localparam logic [AW:0]     NUM_N = (AW+1)'(NUM_NEURONS);
    localparam logic [AW-1:0]   LAST  = AW'(NUM_NEURONS - 1);
    localparam logic [CW-1:0]   LAT   = CW'(DP_LATENCY);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                             state, state_next;
    logic [NUM_NEURONS-1:0][IN_W-1:0]   w;
    logic [IN_W-1:0]                    in_reg;
    logic [IN_W-1:0]                    w_hold;
    logic [AW-1:0]                      idx;
    logic [CW-1:0]                      cnt;
    logic [NUM_NEURONS-1:0]             acc, acc_next;
    logic                               wr_en;
    logic                               sample;

    // Weights only change while idle; out-of-range addresses are dropped.
    assign wr_en  = cfg_we && (state == IDLE) && ({1'b0, cfg_addr} < NUM_N);
    // The last WAIT cycle is exactly DP_LATENCY cycles after the issue strobe.
    assign sample = (state == WAIT) && (cnt == CW'(1));
    // in_reg only changes on start acceptance, which is always followed by an
    // issue, so it always equals the last issued input vector.
    assign dp_in  = in_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (sample) state_next = (idx == LAST) ? DONE : ISSUE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; dp_weight holds the last issued word outside ISSUE.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        dp_valid  = (state == ISSUE);
        dp_weight = (state == ISSUE) ? w[idx] : w_hold;
    end

    // Accumulator with the current neuron's result merged in on its sample cycle.
    always_comb begin
        acc_next = acc;
        if (sample) acc_next[idx] = dp_result;
    end

    // Weight bank, run context, latency counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w       <= '0;
            in_reg  <= '0;
            w_hold  <= '0;
            idx     <= '0;
            cnt     <= '0;
            acc     <= '0;
            out_vec <= '0;
        end else begin
            if (wr_en) w[cfg_addr] <= cfg_wdata;
            case (state)
                IDLE: begin
                    if (start) begin
                        in_reg <= in_data;
                        idx    <= '0;
                        acc    <= '0;
                    end
                end
                ISSUE: begin
                    cnt    <= LAT;
                    w_hold <= w[idx];
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (sample) begin
                        acc <= acc_next;
                        // Publish the whole vector at once so it is valid in the done cycle.
                        if (idx == LAST) out_vec <= acc_next;
                        else             idx     <= idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Self-checking bench for bnn_layer_sequencer: a behavioural datapath model
// answers each issue after DP_LATENCY cycles (random noise otherwise), and
// each layer run is compared against a weight-array reference model.
module tb_bnn_layer_sequencer;

    localparam int IN_W = 8;
    localparam int NN   = 4;
    localparam int L    = 2;
    localparam int AW   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_we = 1'b0;
    logic [AW-1:0]   cfg_addr = '0;
    logic [IN_W-1:0] cfg_wdata = '0;
    logic            start = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    logic            dp_result = 1'b0;
    logic            busy, done, dp_valid;
    logic [NN-1:0]   out_vec;
    logic [IN_W-1:0] dp_in, dp_weight;

    int n_tests = 0;
    int n_fail  = 0;
    logic [IN_W-1:0] wm [NN];

    bnn_layer_sequencer #(.IN_W(IN_W), .NUM_NEURONS(NN), .DP_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .in_data(in_data), .busy(busy),
        .done(done), .out_vec(out_vec), .dp_valid(dp_valid), .dp_in(dp_in),
        .dp_weight(dp_weight), .dp_result(dp_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic neuron(input logic [IN_W-1:0] x, input logic [IN_W-1:0] wt);
        return $countones(~(x ^ wt)) >= 4;
    endfunction

    function automatic logic [NN-1:0] layer(input logic [IN_W-1:0] x);
        logic [NN-1:0] r;
        for (int i = 0; i < NN; i++) r[i] = neuron(x, wm[i]);
        return r;
    endfunction

    // Datapath model: answers an issue exactly L cycles later, noise otherwise.
    int   cyc = 0;
    logic hv [8] = '{default: 1'b0};
    logic hr [8] = '{default: 1'b0};
    always @(negedge clk) begin
        hv[cyc % 8] = dp_valid;
        hr[cyc % 8] = neuron(dp_in, dp_weight);
        if (cyc >= L && hv[(cyc - L) % 8]) dp_result = hr[(cyc - L) % 8];
        else                               dp_result = 1'($urandom);
        cyc++;
    end

    // Single idle-time weight write; caller is at a negedge.
    task automatic cfg_write(input int a, input logic [IN_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        wm[a] = d;
    endtask

    // One full layer run from IDLE; start is re-asserted in the done cycle.
    task automatic run_layer(input logic [IN_W-1:0] x, input bit cfg_with_start,
                             input int ca, input logic [IN_W-1:0] cd, input bit noise);
        logic [NN-1:0] prev, exp;
        logic [31:0]   iss_mask, exp_mask;
        int            done_cyc, n_iss;
        bit            hold_ok, busy_ok, quiet_ok;
        prev  = out_vec;
        start = 1'b1; in_data = x;
        if (cfg_with_start) begin
            cfg_we = 1'b1; cfg_addr = AW'(ca); cfg_wdata = cd; wm[ca] = cd;
        end
        exp = layer(x);
        exp_mask = '0;
        for (int i = 0; i < NN; i++) exp_mask[1 + i*(1+L)] = 1'b1;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        done_cyc = 0; n_iss = 0; hold_ok = 1; busy_ok = 1; iss_mask = '0;
        for (int k = 1; k <= 30 && done_cyc == 0; k++) begin
            if (dp_valid) begin
                iss_mask[k] = 1'b1;
                check("dp_in", 32'(dp_in), 32'(x));
                if (n_iss < NN) check("dp_weight", 32'(dp_weight), 32'(wm[n_iss]));
                n_iss++;
            end
            if (!busy) busy_ok = 0;
            if (done) done_cyc = k;
            else if (out_vec !== prev) hold_ok = 0;
            if (done) begin
                start = 1'b1; cfg_we = 1'b0;
            end else if (noise) begin
                in_data   = IN_W'($urandom);
                start     = 1'($urandom);
                cfg_we    = 1'($urandom);
                cfg_addr  = AW'($urandom);
                cfg_wdata = IN_W'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0; cfg_we = 1'b0;
        check("done_cycle", 32'(done_cyc), 32'(NN*(1+L)+1));
        check("out_vec", 32'(out_vec), 32'(exp));
        check("issue_cycles", iss_mask, exp_mask);
        check("out_hold", 32'(hold_ok), 32'd1);
        check("busy_run", 32'(busy_ok), 32'd1);
        check("idle_after_done", 32'(busy), 32'd0);
        quiet_ok = 1;
        repeat (3) begin
            if (dp_valid || done || busy) quiet_ok = 0;
            @(negedge clk);
        end
        check("start_in_done_ignored", 32'(quiet_ok), 32'd1);
    endtask

    initial begin
        bit no_done;
        logic [NN-1:0] ev;
        for (int i = 0; i < NN; i++) wm[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dp_valid", 32'(dp_valid), 32'd0);
        check("rst_out_vec", 32'(out_vec), 32'd0);
        check("rst_dp_in", 32'(dp_in), 32'd0);
        check("rst_dp_weight", 32'(dp_weight), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run and the second input pattern.
        cfg_write(0, 8'hFF); cfg_write(1, 8'h00); cfg_write(2, 8'h0F); cfg_write(3, 8'hAA);
        run_layer(8'hFF, 0, 0, 8'h00, 0);
        check("t1_out", 32'(out_vec), 32'(4'b1101));
        run_layer(8'h00, 0, 0, 8'h00, 0);
        check("t2_out", 32'(out_vec), 32'(4'b1110));

        // Mid-run writes/starts/input changes must not disturb the run.
        run_layer(8'hFF, 0, 0, 8'h00, 1);
        check("t3_out", 32'(out_vec), 32'(4'b1101));
        // Write together with start: run uses the new weight.
        run_layer(8'hFF, 1, 1, 8'hFF, 0);
        check("t4_out", 32'(out_vec), 32'(4'b1111));

        // Reset in cycle 6 of a run.
        start = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_vec", 32'(out_vec), 32'd0);
        check("midrst_dp_valid", 32'(dp_valid), 32'd0);
        for (int i = 0; i < NN; i++) wm[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        no_done = 1;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) no_done = 0;
        end
        check("midrst_no_done", 32'(no_done), 32'd1);
        // All-zero weights after reset: all-zero input matches every neuron.
        run_layer(8'h00, 0, 0, 8'h00, 0);
        check("t5_out", 32'(out_vec), 32'(4'b1111));
        ev = layer(8'hFF);
        check("t5_model_ff", 32'(ev), 32'(4'b0000));

        // Randomized runs.
        for (int it = 0; it < 15; it++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int j = 0; j < nw; j++) cfg_write($urandom_range(0, NN-1), IN_W'($urandom));
            run_layer(IN_W'($urandom), 1'($urandom), $urandom_range(0, NN-1),
                      IN_W'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
